// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_framed
//  Description : Oversampling UART receiver with filtered input, parity,
//                stop/break detection, overrun flag and line-idle reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_break,
  output logic                 RxD_idle,
  output logic                 RxD_endofpacket
);

  localparam int PW = $clog2(OVERSAMPLING);
  localparam int GW = $clog2(2*OVERSAMPLING+1);
  localparam logic [31:0]   C_FREQ     = 32'(CLK_FREQ);
  localparam logic [31:0]   C_INC      = 32'(BAUD*OVERSAMPLING);
  localparam logic [PW-1:0] C_HALF     = PW'(OVERSAMPLING/2-1);
  localparam logic [PW-1:0] C_LAST     = PW'(OVERSAMPLING-1);
  localparam logic [3:0]    C_LASTBIT  = 4'(DATA_BITS-1);
  localparam logic          C_LASTSTOP = 1'(STOP_BITS-1);
  localparam logic [GW-1:0] C_GAPMAX   = GW'(2*OVERSAMPLING);
  localparam logic [GW-1:0] C_GAPPRE   = GW'(2*OVERSAMPLING-1);

  if (CLK_FREQ < BAUD*OVERSAMPLING) begin : g_badClk
    $error("uart_rx_framed: CLK_FREQ must be >= BAUD*OVERSAMPLING");
  end
  if (OVERSAMPLING < 8 || (OVERSAMPLING & (OVERSAMPLING-1)) != 0) begin : g_badOs
    $error("uart_rx_framed: OVERSAMPLING must be a power of 2 and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_badFormat
    $error("uart_rx_framed: unsupported frame format");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} stateT;

  stateT                r_state;
  logic [31:0]          r_acc;
  logic [1:0]           r_sync;
  logic [1:0]           r_fc;
  logic                 r_filt;
  logic [PW-1:0]        r_phase;
  logic [3:0]           r_bitIdx;
  logic                 r_stopIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parErr;
  logic                 r_frameErr;
  logic                 r_allZero;
  logic                 r_done;
  logic [GW-1:0]        r_gap;

  logic [31:0] w_accSum;
  logic        w_tick;
  logic [1:0]  w_fcNext;
  logic        w_parExp;
  logic        w_brk;

  assign w_accSum = r_acc + C_INC;
  assign w_tick   = (w_accSum >= C_FREQ);
  assign w_parExp = (PARITY == 2) ? ^r_shift : ~(^r_shift);
  // Break: every bit up to and including the first stop bit was zero.
  assign w_brk    = r_allZero & (r_stopIdx | ~r_filt);

  always_comb begin
    w_fcNext = r_fc;
    if (r_sync[1] && r_fc != 2'b11)
      w_fcNext = r_fc + 2'd1;
    else if (!r_sync[1] && r_fc != 2'b00)
      w_fcNext = r_fc - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_sync <= 2'b11;
      r_fc   <= 2'b11;
      r_filt <= 1'b1;
    end else begin
      r_acc  <= w_tick ? (w_accSum - C_FREQ) : w_accSum;
      r_sync <= {r_sync[0], RxD};
      if (w_tick) begin
        r_fc <= w_fcNext;
        if (w_fcNext == 2'b11)
          r_filt <= 1'b1;
        else if (w_fcNext == 2'b00)
          r_filt <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bitIdx   <= '0;
      r_stopIdx  <= 1'b0;
      r_shift    <= '0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
      r_allZero  <= 1'b0;
      r_done     <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (rx_break && r_filt)
        rx_break <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            // A held-low break line must return high before a new start.
            if (!r_filt && !rx_break) begin
              r_state    <= S_START;
              r_phase    <= '0;
              r_bitIdx   <= '0;
              r_stopIdx  <= 1'b0;
              r_parErr   <= 1'b0;
              r_frameErr <= 1'b0;
              r_allZero  <= 1'b1;
            end
          end
          S_START: begin
            if (r_phase == C_HALF) begin
              r_phase <= '0;
              r_state <= r_filt ? S_IDLE : S_DATA;
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          S_DATA: begin
            if (r_phase == C_LAST) begin
              r_phase <= '0;
              r_shift <= {r_filt, r_shift[DATA_BITS-1:1]};
              if (r_filt)
                r_allZero <= 1'b0;
              if (r_bitIdx == C_LASTBIT) begin
                r_bitIdx <= '0;
                r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                r_bitIdx <= r_bitIdx + 4'd1;
              end
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          S_PARITY: begin
            if (r_phase == C_LAST) begin
              r_phase  <= '0;
              r_parErr <= (r_filt != w_parExp);
              if (r_filt)
                r_allZero <= 1'b0;
              r_state  <= S_STOP;
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          S_STOP: begin
            if (r_phase == C_LAST) begin
              r_phase <= '0;
              if (!r_filt)
                r_frameErr <= 1'b1;
              if (!r_stopIdx && r_filt)
                r_allZero <= 1'b0;
              if (r_stopIdx == C_LASTSTOP) begin
                r_state <= S_IDLE;
                if (w_brk)
                  rx_break <= 1'b1;
                else
                  r_done <= 1'b1;
              end else begin
                r_stopIdx <= 1'b1;
              end
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (r_done) begin
      if (rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else begin
        rx_data    <= r_shift;
        parity_err <= r_parErr;
        frame_err  <= r_frameErr;
        rx_valid   <= 1'b1;
        if (rx_ack)
          overrun <= 1'b0;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap           <= '0;
      RxD_idle        <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      RxD_endofpacket <= 1'b0;
      if (r_state != S_IDLE) begin
        r_gap    <= '0;
        RxD_idle <= 1'b0;
      end else if (w_tick && r_gap != C_GAPMAX) begin
        r_gap <= r_gap + GW'(1);
        if (r_gap == C_GAPPRE) begin
          RxD_idle        <= 1'b1;
          RxD_endofpacket <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_framed
//  Description : Directed self-checking bench for uart_rx_framed (16 clk/bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd0, rxd2;
  logic       ack0, ack2;
  logic [7:0] data0, data2;
  logic       valid0, valid2, parErr0, parErr2, frmErr0, frmErr2;
  logic       ovr0, ovr2, brk0, brk2, idle0, idle2, eop0, eop2;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  uart_rx_framed #(
    .CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLING(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd0), .rx_data(data0), .rx_valid(valid0),
    .rx_ack(ack0), .parity_err(parErr0), .frame_err(frmErr0), .overrun(ovr0),
    .rx_break(brk0), .RxD_idle(idle0), .RxD_endofpacket(eop0)
  );

  uart_rx_framed #(
    .CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLING(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .RxD(rxd2), .rx_data(data2), .rx_valid(valid2),
    .rx_ack(ack2), .parity_err(parErr2), .frame_err(frmErr2), .overrun(ovr2),
    .rx_break(brk2), .RxD_idle(idle2), .RxD_endofpacket(eop2)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame (bit 0 first) on the chosen line, one clk per tick; optional
  // one-cycle ack and reset pulse at given cycle offsets from the start bit.
  task automatic sendFrame(input int sel, input logic [15:0] bits, input int nBits,
                           input int ackCyc, input int rstCyc);
    for (int c = 0; c < nBits*16; c++) begin
      if (sel == 0) rxd0 = bits[c/16];
      else          rxd2 = bits[c/16];
      ack0 = (sel == 0 && c == ackCyc);
      if (c == rstCyc)     rst_n = 1'b0;
      if (c == rstCyc + 2) rst_n = 1'b1;
      @(negedge clk);
    end
    ack0 = 1'b0;
  endtask

  task automatic idleLine(input int n);
    rxd0 = 1'b1;
    rxd2 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseAck(input int sel);
    if (sel == 0) ack0 = 1'b1; else ack2 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack2 = 1'b0;
  endtask

  initial begin
    int eopCnt;
    rst_n = 1'b0;
    rxd0  = 1'b1;
    rxd2  = 1'b1;
    ack0  = 1'b0;
    ack2  = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("rst_valid", valid0, 0);
    checkEq("rst_data", data0, 0);
    checkEq("rst_overrun", ovr0, 0);
    checkEq("rst_break", brk0, 0);
    checkEq("rst_idle", idle0, 0);
    checkEq("rst_eop", eop0, 0);
    checkEq("rst_valid2", valid2, 0);
    rst_n = 1'b1;

    // Line idle after reset: exactly one end-of-packet pulse, then idle held.
    eopCnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (eop0) eopCnt++;
    end
    checkEq("eop_count", eopCnt, 1);
    checkEq("idle_high", idle0, 1);
    checkEq("idle_high2", idle2, 1);

    // Plain word 0xA5
    sendFrame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, -100);
    checkEq("a5_valid", valid0, 1);
    checkEq("a5_data", data0, 8'hA5);
    checkEq("a5_parerr", parErr0, 0);
    checkEq("a5_frmerr", frmErr0, 0);
    checkEq("a5_busy_idle", idle0, 0);
    pulseAck(0);
    checkEq("a5_ack_clears", valid0, 0);
    idleLine(20);

    // 0x55 with a low stop bit: framing error
    sendFrame(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10, -1, -100);
    checkEq("fe_valid", valid0, 1);
    checkEq("fe_data", data0, 8'h55);
    checkEq("fe_frmerr", frmErr0, 1);
    idleLine(30);
    pulseAck(0);
    checkEq("fe_ack_clears", valid0, 0);
    idleLine(20);

    // Break: all zero including the stop bit, line held low
    sendFrame(0, 16'h0000, 10, -1, -100);
    repeat (32) @(negedge clk);
    checkEq("brk_set", brk0, 1);
    checkEq("brk_noword", valid0, 0);
    idleLine(20);
    checkEq("brk_clear", brk0, 0);
    checkEq("brk_noword_after", valid0, 0);

    // Overrun: second word dropped while the first is unread
    sendFrame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1, -100);
    idleLine(20);
    checkEq("ov_first", data0, 8'h11);
    sendFrame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, -100);
    checkEq("ov_data_kept", data0, 8'h11);
    checkEq("ov_flag", ovr0, 1);
    checkEq("ov_valid", valid0, 1);
    idleLine(20);
    // Ack in the completion cycle of the next word: it loads, overrun clears
    sendFrame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 158, -100);
    checkEq("ackcomp_data", data0, 8'h22);
    checkEq("ackcomp_overrun", ovr0, 0);
    checkEq("ackcomp_valid", valid0, 1);
    pulseAck(0);
    checkEq("ackcomp_clear", valid0, 0);
    idleLine(20);

    // 6-clock glitch is a false start
    rxd0 = 1'b0;
    repeat (6) @(negedge clk);
    idleLine(60);
    checkEq("glitch_noword", valid0, 0);
    checkEq("glitch_data", data0, 8'h22);

    // Reset during data bit 3 of 0xFF abandons the frame
    sendFrame(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, -1, 70);
    idleLine(40);
    checkEq("rstmid_noword", valid0, 0);
    checkEq("rstmid_data", data0, 0);

    // Even parity: 0x03 has even ones, correct parity bit is 0
    idleLine(20);
    sendFrame(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, -100);
    checkEq("par_bad_valid", valid2, 1);
    checkEq("par_bad_data", data2, 8'h03);
    checkEq("par_bad_err", parErr2, 1);
    checkEq("par_bad_frm", frmErr2, 0);
    pulseAck(2);
    checkEq("par_ack_clears", valid2, 0);
    idleLine(20);
    sendFrame(2, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1, -100);
    checkEq("par_ok_valid", valid2, 1);
    checkEq("par_ok_data", data2, 8'h03);
    checkEq("par_ok_err", parErr2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, meaning: clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning: line bit rate.
REQ-003 Parameter OVERSAMPLING, default 8, meaning: ticks per bit; power of 2, >=8; CLK_FREQ >= BAUD*OVERSAMPLING, else elaboration error.
REQ-004 Parameter DATA_BITS, default 8, meaning: data width, 5..9.
REQ-005 Parameter PARITY, default 0, meaning: 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, default 1, meaning: 1 or 2.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 RxD  input  1  serial line, idle high, asynchronous to clk.
REQ-010 rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-011 rx_valid  output  1  rx_data holds an unread word.
REQ-012 rx_ack  input  1  consumer has taken rx_data.
REQ-013 parity_err  output  1  parity mismatch for the word in rx_data.
REQ-014 frame_err  output  1  a stop bit was sampled low for the word in rx_data.
REQ-015 overrun  output  1  sticky; a word was dropped while rx_valid=1.
REQ-016 rx_break  output  1  high while the line is a break (see REQ-027).
REQ-017 RxD_idle  output  1  no start bit for 2*OVERSAMPLING ticks.
REQ-018 RxD_endofpacket  output  1  one-cycle pulse when RxD_idle rises.

Function
REQ-019 Internal accumulator tick generator SHALL pulse tick at BAUD*OVERSAMPLING Hz average; all line logic advances only on tick.
REQ-020 RxD SHALL pass a 2-flop synchroniser then a 2-bit saturating filter; filtered bit changes only when counter is 11 (->1) or 00 (->0).
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on filtered bit 0.
REQ-022 Bit-phase counter SHALL reset on entering START; sample point = count OVERSAMPLING/2-1, then every OVERSAMPLING ticks.
REQ-023 START: at sample point, bit 1 -> IDLE (false start, nothing reported); bit 0 -> DATA.
REQ-024 DATA: shift DATA_BITS samples LSB-first; then PARITY if PARITY!=0, else STOP.
REQ-025 PARITY: compare sampled bit with XOR of data (even) or its inverse (odd); result latched with the word.
REQ-026 STOP: sample STOP_BITS bits; any low sets frame error; after last sample -> IDLE, no wait for line high.
REQ-027 Break: all data bits, parity and first stop bit sampled 0 -> word discarded, rx_break set; rx_break clears when filtered bit returns 1.
REQ-028 Word completion: cycle after last stop sample, rx_data, parity_err, frame_err load and rx_valid=1.
REQ-029 rx_valid stays high until a cycle with rx_ack=1; clears next cycle; rx_ack with rx_valid=0 ignored.
REQ-030 Completion while rx_valid=1 and no rx_ack same cycle: new word dropped, rx_data unchanged, overrun=1.
REQ-031 Completion and rx_ack same cycle: new word loads, rx_valid stays 1, no overrun.
REQ-032 overrun clears only on rx_ack.
REQ-033 Gap counter: cleared when FSM not IDLE, else increments per tick saturating at 2*OVERSAMPLING; RxD_idle = saturated; RxD_endofpacket pulses on the tick it saturates.

Reset
REQ-034 rst_n low SHALL immediately force FSM IDLE, sync/filter to 1, counters 0, rx_data 0, rx_valid/parity_err/frame_err/overrun/rx_break/RxD_endofpacket 0, RxD_idle 0.
REQ-035 Reset mid-frame SHALL abandon the frame; no word reported after release.

Verification (CLK_FREQ=1843200, BAUD=115200, OVERSAMPLING=16: tick every clk, 16 clk/bit)
REQ-036 DATA_BITS=8, PARITY=0: send 0xA5 -> rx_data=0xA5, rx_valid=1, errors 0; rx_ack -> rx_valid 0 next cycle.
REQ-037 PARITY=2: send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; parity bit 0 -> parity_err=0.
REQ-038 Send 0x55 with stop bit low -> frame_err=1; 0x00 with stop low -> no word, rx_break=1 until line high.
REQ-039 Send 0x11, 0x22 without rx_ack -> rx_data=0x11, overrun=1; ack on 0x22 completion cycle -> rx_data=0x22, overrun=0.
REQ-040 6-clk low glitch -> no word; assert rst_n low during bit 3 of 0xFF -> no rx_valid; line idle 32 ticks -> one RxD_endofpacket pulse, RxD_idle=1.
